// File: rtl/bin_packer.sv
// Sweeps the binary map in raster order and packs 8 pixels per byte, MSB first.
// Each byte takes 9 cycles (8 reads + 1 handshake). A stalled byte holds its data and the read address.
module bin_packer #(
   parameter int WIDTH  = 256,
   parameter int HEIGHT = 256,
   parameter int ADDR_W = 16
) (
   input  logic              bin_clk,
   input  logic              bin_rst,
   input  logic              start,
   output logic [ADDR_W-1:0] pixel_address,
   input  logic              bin_data,
   output logic [7:0]        byte_data,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              busy,
   output logic              done,
   output logic [1:0]        condition_led
);

   localparam logic [ADDR_W-4:0] LAST_BYTE = (ADDR_W-3)'(WIDTH*HEIGHT/8 - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        shreg;
   logic [2:0]        bit_cnt;
   logic [ADDR_W-4:0] byte_cnt;
   logic              frame_complete;
   logic              accept;
   logic              last_accept;

   assign accept      = (state_q == SEND) && byte_valid && byte_ready;
   assign last_accept = accept && (byte_cnt == LAST_BYTE);

   always_ff @(posedge bin_clk or posedge bin_rst) begin
      if (bin_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = READ;
         READ:    if (bit_cnt == 3'd7) state_d = SEND;
         SEND:    if (accept) state_d = last_accept ? IDLE : READ;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge bin_clk or posedge bin_rst) begin
      if (bin_rst) begin
         pixel_address  <= '0;
         shreg          <= '0;
         bit_cnt        <= '0;
         byte_cnt       <= '0;
         byte_data      <= '0;
         byte_valid     <= 1'b0;
         done           <= 1'b0;
         frame_complete <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  pixel_address  <= '0;
                  bit_cnt        <= '0;
                  byte_cnt       <= '0;
                  frame_complete <= 1'b0;
               end
            end
            READ: begin
               shreg         <= {shreg[6:0], bin_data};
               pixel_address <= pixel_address + 1'b1;
               bit_cnt       <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  byte_data  <= {shreg[6:0], bin_data};
                  byte_valid <= 1'b1;
               end
            end
            SEND: begin
               // bit_cnt already wrapped to 0 on the eighth read
               if (accept) begin
                  byte_valid <= 1'b0;
                  byte_cnt   <= byte_cnt + 1'b1;
                  bit_cnt    <= '0;
                  if (last_accept) begin
                     done           <= 1'b1;
                     frame_complete <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy          = (state_q != IDLE);
   assign condition_led = {frame_complete, busy};

endmodule
